// File: rtl/cfg_loader_pkg.sv
// Shared types and frame-length helper for the serial configuration loader.
// CFG_LOADER_PARITY_EN adds one trailing even-parity bit to every frame.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  function automatic int frame_len(input int width);
`ifdef CFG_LOADER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/cfg_shreg.sv
// Frame-wide serial-in shift register; i_start restarts a frame with the first bit.
// With CFG_LOADER_PARITY_EN a running XOR of every shifted bit is kept alongside.
module cfg_shreg
  import cfg_loader_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_shift,
  input  logic             i_sdi,
`ifdef CFG_LOADER_PARITY_EN
  output logic             o_parity,
`endif
  output logic [WIDTH-1:0] o_data
);

  localparam int FRAME = frame_len(WIDTH);

  logic [FRAME-1:0] r_shreg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shreg <= '0;
    end else if (i_start) begin
      r_shreg <= {{(FRAME-1){1'b0}}, i_sdi};
    end else if (i_shift) begin
      r_shreg <= {r_shreg[FRAME-2:0], i_sdi};
    end
  end

  // The data bits are the first WIDTH bits shifted in, i.e. the top of the register.
  assign o_data = r_shreg[FRAME-1 -: WIDTH];

`ifdef CFG_LOADER_PARITY_EN
  logic r_parity;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_parity <= 1'b0;
    end else if (i_start) begin
      r_parity <= i_sdi;
    end else if (i_shift) begin
      r_parity <= r_parity ^ i_sdi;
    end
  end

  assign o_parity = r_parity;
`endif

endmodule

// File: rtl/cfg_shift_loader.sv
// Serial configuration loader: frames SDI bits and commits them atomically to CFG.
// CFG_LOADER_PARITY_EN enables a trailing even-parity bit checked before commit.
//
//   state  | meaning
//   IDLE   | waiting for the first SEN=1 of a frame
//   SHIFT  | collecting frame bits, validates framing on first SEN=0
//   COMMIT | one cycle; CFG loads on leaving, DONE pulses with it
module cfg_shift_loader
  import cfg_loader_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SDI,
  input  logic             SEN,
  output logic [WIDTH-1:0] CFG,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int FRAME = frame_len(WIDTH);
  localparam int CW    = $clog2(WIDTH + 3);
  localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME);
  localparam logic [CW-1:0] CNT_OVER  = CW'(FRAME + 1);

  cfg_state_t       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_cfg;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_start;
  logic             w_shift;
  logic             w_par_ok;
  logic [WIDTH-1:0] w_data;

  assign w_start = (r_state == IDLE)  && SEN;
  assign w_shift = (r_state == SHIFT) && SEN;

`ifdef CFG_LOADER_PARITY_EN
  logic w_parity;

  cfg_shreg #(.WIDTH(WIDTH)) u_shreg (
    .i_clk    (CLK),
    .i_rst_n  (RESET),
    .i_start  (w_start),
    .i_shift  (w_shift),
    .i_sdi    (SDI),
    .o_parity (w_parity),
    .o_data   (w_data)
  );

  assign w_par_ok = ~w_parity;
`else
  cfg_shreg #(.WIDTH(WIDTH)) u_shreg (
    .i_clk    (CLK),
    .i_rst_n  (RESET),
    .i_start  (w_start),
    .i_shift  (w_shift),
    .i_sdi    (SDI),
    .o_data   (w_data)
  );

  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_count <= '0;
      r_cfg   <= RESET_VAL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (SEN) begin
            r_count <= CW'(1);
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (SEN) begin
            // Saturate one past FRAME so any overrun stays detectable.
            if (r_count != CNT_OVER) begin
              r_count <= r_count + CW'(1);
            end
          end else if ((r_count == CNT_FRAME) && w_par_ok) begin
            r_state <= COMMIT;
          end else begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        COMMIT: begin
          r_cfg   <= w_data;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign CFG  = r_cfg;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ERR  = r_err;

endmodule
